// File: rtl/hilo_ctrl.sv
// HI/LO controller: decodes HI/LO-class EX instructions, issues MUL/DIV requests
// to the multiply/divide unit and collects the 64-bit result into HI/LO.
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic        ex_sign,
    input  logic [31:0] ex_src0,
    input  logic [31:0] ex_src1,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic [31:0] ex_rdata,
    output logic [31:0] md_in_src0,
    output logic [31:0] md_in_src1,
    output logic [1:0]  md_in_op,
    output logic        md_in_sign,
    output logic        md_in_valid,
    input  logic        md_in_ready,
    input  logic        md_out_valid,
    output logic        md_out_ready,
    input  logic [31:0] md_res0,
    input  logic [31:0] md_res1,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; the sender holds valid and payload stable until that edge.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] src0_q, src0_d, src1_q, src1_d;
    logic [1:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic        md_in_valid_q, md_in_valid_d;
    logic        md_out_ready_q, md_out_ready_d;

    logic ex_live, is_md, is_hilo, idle;

    always_comb begin
        ex_live  = ex_valid & ~ex_flush;
        is_md    = (ex_op == OP_MULT) | (ex_op == OP_DIV);
        is_hilo  = (ex_op >= OP_MULT) & (ex_op <= OP_MFLO);
        idle     = (state_q == ST_IDLE);
        ex_stall = ex_live & is_hilo & ~idle;
        ex_rdata = 32'd0;
        if (ex_live & idle) begin
            if (ex_op == OP_MFHI) ex_rdata = hi_q;
            else if (ex_op == OP_MFLO) ex_rdata = lo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_live & is_md) begin
                    src0_d  = ex_src0;
                    src1_d  = ex_src1;
                    sign_d  = ex_sign;
                    op_d    = (ex_op == OP_MULT) ? 2'b01 : 2'b10;
                    state_d = ST_ISSUE;
                end else if (ex_live & (ex_op == OP_MTHI)) begin
                    hi_d = ex_src0;
                end else if (ex_live & (ex_op == OP_MTLO)) begin
                    lo_d = ex_src0;
                end
            end
            ST_ISSUE: begin
                if (md_in_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The operation has already retired, so a flush in EX cannot cancel it.
                if (md_out_valid) begin
                    hi_d    = md_res1;
                    lo_d    = md_res0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        md_in_valid_d  = (state_d == ST_ISSUE);
        md_out_ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
            src0_q         <= 32'd0;
            src1_q         <= 32'd0;
            op_q           <= 2'b00;
            sign_q         <= 1'b0;
            md_in_valid_q  <= 1'b0;
            md_out_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            src0_q         <= src0_d;
            src1_q         <= src1_d;
            op_q           <= op_d;
            sign_q         <= sign_d;
            md_in_valid_q  <= md_in_valid_d;
            md_out_ready_q <= md_out_ready_d;
        end
    end

    assign md_in_src0   = src0_q;
    assign md_in_src1   = src1_q;
    assign md_in_op     = op_q;
    assign md_in_sign   = sign_q;
    assign md_in_valid  = md_in_valid_q;
    assign md_out_ready = md_out_ready_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed testbench for hilo_ctrl; the bench plays the multiply/divide unit
// and supplies hand-computed results.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'd0;
    logic        ex_sign = 1'b0;
    logic [31:0] ex_src0 = 32'd0;
    logic [31:0] ex_src1 = 32'd0;
    logic        ex_flush = 1'b0;
    logic        ex_stall;
    logic [31:0] ex_rdata;
    logic [31:0] md_in_src0, md_in_src1;
    logic [1:0]  md_in_op;
    logic        md_in_sign, md_in_valid;
    logic        md_in_ready = 1'b0;
    logic        md_out_valid = 1'b0;
    logic        md_out_ready;
    logic [31:0] md_res0 = 32'd0;
    logic [31:0] md_res1 = 32'd0;
    logic [31:0] hi, lo;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;

    hilo_ctrl dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_sign(ex_sign),
        .ex_src0(ex_src0), .ex_src1(ex_src1), .ex_flush(ex_flush),
        .ex_stall(ex_stall), .ex_rdata(ex_rdata),
        .md_in_src0(md_in_src0), .md_in_src1(md_in_src1),
        .md_in_op(md_in_op), .md_in_sign(md_in_sign),
        .md_in_valid(md_in_valid), .md_in_ready(md_in_ready),
        .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
        .md_res0(md_res0), .md_res1(md_res1),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // count accepted requests to the unit
    always @(posedge clk)
        if (!reset && md_in_valid && md_in_ready) acc_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // drive one EX cycle at the falling edge and let combinational outputs settle
    task automatic cyc(input logic v, input logic [2:0] op, input logic sg,
                       input logic [31:0] s0, input logic [31:0] s1, input logic fl);
        @(negedge clk);
        ex_valid = v; ex_op = op; ex_sign = sg;
        ex_src0 = s0; ex_src1 = s1; ex_flush = fl;
        #1;
    endtask

    task automatic unit(input logic rdy, input logic ov, input logic [31:0] r0, input logic [31:0] r1);
        md_in_ready = rdy; md_out_valid = ov; md_res0 = r0; md_res1 = r1;
    endtask

    initial begin
        // reset
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        check_eq("rst_in_valid", {31'd0, md_in_valid}, 32'd0);
        check_eq("rst_out_ready", {31'd0, md_out_ready}, 32'd0);
        check_eq("rst_src0", md_in_src0, 32'd0);
        check_eq("rst_op", {30'd0, md_in_op}, 32'd0);
        cyc(1, 5, 0, 0, 0, 0);
        check_eq("rst_mfhi", ex_rdata, 32'd0);
        check_eq("rst_mfhi_stall", {31'd0, ex_stall}, 32'd0);
        cyc(1, 6, 0, 0, 0, 0);
        check_eq("rst_mflo", ex_rdata, 32'd0);

        // MTHI / MTLO then read back
        cyc(1, 3, 0, 32'h12345678, 0, 0);
        check_eq("mthi_stall", {31'd0, ex_stall}, 32'd0);
        cyc(1, 5, 0, 0, 0, 0);
        check_eq("mfhi_after_mthi", ex_rdata, 32'h12345678);
        cyc(1, 4, 0, 32'hDEADBEEF, 0, 0);
        cyc(1, 6, 0, 0, 0, 0);
        check_eq("mflo_after_mtlo", ex_rdata, 32'hDEADBEEF);
        check_eq("hi_kept", hi, 32'h12345678);

        // signed MULT -2 * 3 with MFLO held behind it
        cyc(1, 1, 1, 32'hFFFFFFFE, 32'd3, 0);
        unit(1, 0, 0, 0);
        check_eq("mult_stall0", {31'd0, ex_stall}, 32'd0);
        cyc(1, 6, 0, 0, 0, 0);
        check_eq("mult_in_valid", {31'd0, md_in_valid}, 32'd1);
        check_eq("mult_src0", md_in_src0, 32'hFFFFFFFE);
        check_eq("mult_src1", md_in_src1, 32'd3);
        check_eq("mult_op", {30'd0, md_in_op}, 32'd1);
        check_eq("mult_sign", {31'd0, md_in_sign}, 32'd1);
        check_eq("mflo_stall_issue", {31'd0, ex_stall}, 32'd1);
        check_eq("mflo_rdata_stalled", ex_rdata, 32'd0);
        cyc(1, 6, 0, 0, 0, 0);
        check_eq("wait_state", {30'd0, dbg_state}, 32'd2);
        check_eq("wait_out_ready", {31'd0, md_out_ready}, 32'd1);
        check_eq("wait_in_valid", {31'd0, md_in_valid}, 32'd0);
        check_eq("mflo_stall_wait", {31'd0, ex_stall}, 32'd1);
        cyc(1, 6, 0, 0, 0, 0);
        unit(1, 1, 32'hFFFFFFFA, 32'hFFFFFFFF);
        check_eq("mflo_stall_k", {31'd0, ex_stall}, 32'd1);
        cyc(1, 6, 0, 0, 0, 0);
        unit(1, 0, 0, 0);
        check_eq("mflo_stall_k1", {31'd0, ex_stall}, 32'd0);
        check_eq("mflo_result", ex_rdata, 32'hFFFFFFFA);
        check_eq("mult_hi", hi, 32'hFFFFFFFF);
        check_eq("mult_lo", lo, 32'hFFFFFFFA);

        // DIVU 100 / 7 with ready held low for 3 cycles
        acc_cnt = 0;
        cyc(1, 2, 0, 32'd100, 32'd7, 0);
        unit(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check_eq("div_hold_valid", {31'd0, md_in_valid}, 32'd1);
            check_eq("div_hold_src0", md_in_src0, 32'd100);
            check_eq("div_hold_src1", md_in_src1, 32'd7);
            check_eq("div_hold_op", {30'd0, md_in_op}, 32'd2);
            check_eq("div_hold_sign", {31'd0, md_in_sign}, 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        unit(1, 0, 0, 0);
        check_eq("div_accept_valid", {31'd0, md_in_valid}, 32'd1);
        cyc(1, 7, 0, 0, 0, 0);
        unit(0, 0, 0, 0);
        check_eq("div_rsvd_nostall", {31'd0, ex_stall}, 32'd0);
        check_eq("div_wait_in_valid", {31'd0, md_in_valid}, 32'd0);
        check_eq("div_wait_out_ready", {31'd0, md_out_ready}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        unit(0, 1, 32'd14, 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        unit(0, 0, 0, 0);
        check_eq("div_accept_cnt", acc_cnt, 32'd1);
        check_eq("div_lo", lo, 32'd14);
        check_eq("div_hi", hi, 32'd2);

        // MULT flushed in EX: no issue, HI/LO unchanged
        cyc(1, 1, 1, 32'd5, 32'd5, 1);
        check_eq("flush_stall", {31'd0, ex_stall}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check_eq("flush_in_valid", {31'd0, md_in_valid}, 32'd0);
        check_eq("flush_state", {30'd0, dbg_state}, 32'd0);
        check_eq("flush_hi", hi, 32'd2);
        check_eq("flush_lo", lo, 32'd14);

        // MULTU 7 * 6, flush in EX during WAIT does not cancel it
        cyc(1, 1, 0, 32'd7, 32'd6, 0);
        unit(1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 1);
        unit(1, 1, 32'd42, 32'd0);
        check_eq("wflush_stall", {31'd0, ex_stall}, 32'd0);
        check_eq("wflush_rdata", ex_rdata, 32'd0);
        check_eq("wflush_out_ready", {31'd0, md_out_ready}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        unit(0, 0, 0, 0);
        check_eq("wflush_hi", hi, 32'd0);
        check_eq("wflush_lo", lo, 32'd42);
        check_eq("wflush_state", {30'd0, dbg_state}, 32'd0);

        // reset in WAIT drops the in-flight result
        cyc(1, 1, 0, 32'd9, 32'd9, 0);
        unit(1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        unit(0, 0, 0, 0);
        check_eq("rwait_state", {30'd0, dbg_state}, 32'd2);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        unit(0, 1, 32'd111, 32'd222);
        check_eq("rwait_out_ready", {31'd0, md_out_ready}, 32'd0);
        check_eq("rwait_state_idle", {30'd0, dbg_state}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        unit(0, 0, 0, 0);
        check_eq("rwait_hi", hi, 32'd0);
        check_eq("rwait_lo", lo, 32'd0);
        check_eq("rwait_state_after", {30'd0, dbg_state}, 32'd0);
        check_eq("rwait_out_ready_after", {31'd0, md_out_ready}, 32'd0);
        check_eq("rwait_in_valid", {31'd0, md_in_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
